// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0) and the
// CSR/branch unit (port 1); drives registered operands and returns the captured result.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALUOPS
`define ALUOPS 4
`endif

module alu_arbiter #(
  parameter int XLEN    = `XLEN,
  parameter int ALUOPS  = `ALUOPS,
  parameter int ALU_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [ALUOPS-1:0] i_req0_op,
  input  logic [XLEN-1:0]   i_req0_data_1,
  input  logic [XLEN-1:0]   i_req0_data_2,
  input  logic [4:0]        i_req0_shamt,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [ALUOPS-1:0] i_req1_op,
  input  logic [XLEN-1:0]   i_req1_data_1,
  input  logic [XLEN-1:0]   i_req1_data_2,
  input  logic [4:0]        i_req1_shamt,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [XLEN-1:0]   o_rsp0_result,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [XLEN-1:0]   o_rsp1_result,
  output logic [ALUOPS-1:0] o_alu_op,
  output logic [XLEN-1:0]   o_alu_data_1,
  output logic [XLEN-1:0]   o_alu_data_2,
  output logic [4:0]        o_alu_shamt,
  input  logic [XLEN-1:0]   i_alu_result,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [2:0] LP_LAT = 3'(ALU_LAT);

  state_t            r_state;
  logic [2:0]        r_count;
  logic              r_last_grant;
  logic              r_owner;
  logic [XLEN-1:0]   r_result;
  logic [ALUOPS-1:0] r_alu_op;
  logic [XLEN-1:0]   r_alu_data_1;
  logic [XLEN-1:0]   r_alu_data_2;
  logic [4:0]        r_alu_shamt;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic              r_busy;

  logic              w_grant_any;
  logic              w_grant;
  logic              w_rsp_ready;
  logic [ALUOPS-1:0] w_op;
  logic [XLEN-1:0]   w_data_1;
  logic [XLEN-1:0]   w_data_2;
  logic [4:0]        w_shamt;

  // On a tie the port that was not served last wins; otherwise the lone requester.
  always_comb begin
    w_grant_any = i_req0_valid | i_req1_valid;
    if (i_req0_valid & i_req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = i_req1_valid;
    end
  end

  assign w_op     = w_grant ? i_req1_op     : i_req0_op;
  assign w_data_1 = w_grant ? i_req1_data_1 : i_req0_data_1;
  assign w_data_2 = w_grant ? i_req1_data_2 : i_req0_data_2;
  assign w_shamt  = w_grant ? i_req1_shamt  : i_req0_shamt;

  assign w_rsp_ready = r_owner ? i_rsp1_ready : i_rsp0_ready;

  assign o_req0_ready = (r_state == IDLE) & w_grant_any & ~w_grant;
  assign o_req1_ready = (r_state == IDLE) & w_grant_any &  w_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_result     <= '0;
      r_alu_op     <= '0;
      r_alu_data_1 <= '0;
      r_alu_data_2 <= '0;
      r_alu_shamt  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_alu_op     <= w_op;
            r_alu_data_1 <= w_data_1;
            r_alu_data_2 <= w_data_2;
            r_alu_shamt  <= w_shamt;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_count      <= LP_LAT;
            r_busy       <= 1'b1;
            r_state      <= BUSY;
          end
        end
        // The counter reaching zero marks the cycle the ALU output is settled.
        BUSY: begin
          if (r_count == 3'd0) begin
            r_result     <= i_alu_result;
            r_rsp0_valid <= ~r_owner;
            r_rsp1_valid <= r_owner;
            r_state      <= RESP;
          end else begin
            r_count <= r_count - 3'd1;
          end
        end
        RESP: begin
          if (w_rsp_ready) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_alu_op      = r_alu_op;
  assign o_alu_data_1  = r_alu_data_1;
  assign o_alu_data_2  = r_alu_data_2;
  assign o_alu_shamt   = r_alu_shamt;
  assign o_rsp0_valid  = r_rsp0_valid;
  assign o_rsp1_valid  = r_rsp1_valid;
  assign o_rsp0_result = r_result;
  assign o_rsp1_result = r_result;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
`timescale 1ns/1ps

module tb_alu_arbiter;

  localparam int LAT = 1;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SRA = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req0Valid, req1Valid, req0Ready, req1Ready;
  logic [3:0]  req0Op, req1Op;
  logic [31:0] req0Data1, req0Data2, req1Data1, req1Data2;
  logic [4:0]  req0Shamt, req1Shamt;
  logic        rsp0Valid, rsp1Valid, rsp0Ready, rsp1Ready;
  logic [31:0] rsp0Result, rsp1Result;
  logic [3:0]  aluOp;
  logic [31:0] aluData1, aluData2, aluResult, aluPipe;
  logic [4:0]  aluShamt;
  logic        busy;

  logic        fastValid, fastReady, fastReq1Ready, fastRspValid, fastRsp1Valid, fastBusy;
  logic [3:0]  fastOp, fastAluOp;
  logic [31:0] fastData1, fastData2, fastRspResult, fastRsp1Result;
  logic [31:0] fastAluData1, fastAluData2, fastAluResult;
  logic [4:0]  fastAluShamt;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleNum = 0;

  bit          mIdle, mOwner, mLastGrant;
  int          mRespCycle;
  logic [31:0] mResult, mAluData1, mAluData2;
  logic [3:0]  mAluOp;
  logic [4:0]  mAluShamt;

  bit          acc0, acc1;
  int          grantLog[$];
  logic [31:0] gotRsp0, gotRsp1;

  function automatic logic [31:0] aluRef(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                         logic [4:0] sh);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return $signed(a) >>> sh;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      default: return a + b;
    endcase
  endfunction

  // The ALU itself is environment: one-cycle pipelined for the main DUT, combinational for the fast one.
  always_ff @(posedge clk) aluPipe <= aluRef(aluOp, aluData1, aluData2, aluShamt);
  assign aluResult     = aluPipe;
  assign fastAluResult = aluRef(fastAluOp, fastAluData1, fastAluData2, fastAluShamt);

  alu_arbiter #(.XLEN(32), .ALUOPS(4), .ALU_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0Valid), .o_req0_ready(req0Ready), .i_req0_op(req0Op),
    .i_req0_data_1(req0Data1), .i_req0_data_2(req0Data2), .i_req0_shamt(req0Shamt),
    .i_req1_valid(req1Valid), .o_req1_ready(req1Ready), .i_req1_op(req1Op),
    .i_req1_data_1(req1Data1), .i_req1_data_2(req1Data2), .i_req1_shamt(req1Shamt),
    .o_rsp0_valid(rsp0Valid), .i_rsp0_ready(rsp0Ready), .o_rsp0_result(rsp0Result),
    .o_rsp1_valid(rsp1Valid), .i_rsp1_ready(rsp1Ready), .o_rsp1_result(rsp1Result),
    .o_alu_op(aluOp), .o_alu_data_1(aluData1), .o_alu_data_2(aluData2),
    .o_alu_shamt(aluShamt), .i_alu_result(aluResult), .o_busy(busy)
  );

  alu_arbiter #(.XLEN(32), .ALUOPS(4), .ALU_LAT(0)) dutFast (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(fastValid), .o_req0_ready(fastReady), .i_req0_op(fastOp),
    .i_req0_data_1(fastData1), .i_req0_data_2(fastData2), .i_req0_shamt(5'd0),
    .i_req1_valid(1'b0), .o_req1_ready(fastReq1Ready), .i_req1_op(4'd0),
    .i_req1_data_1(32'd0), .i_req1_data_2(32'd0), .i_req1_shamt(5'd0),
    .o_rsp0_valid(fastRspValid), .i_rsp0_ready(1'b1), .o_rsp0_result(fastRspResult),
    .o_rsp1_valid(fastRsp1Valid), .i_rsp1_ready(1'b1), .o_rsp1_result(fastRsp1Result),
    .o_alu_op(fastAluOp), .o_alu_data_1(fastAluData1), .o_alu_data_2(fastAluData2),
    .o_alu_shamt(fastAluShamt), .i_alu_result(fastAluResult), .o_busy(fastBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycleNum);
    end
  endtask

  task automatic applyStimulus(input int port, input bit valid, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    if (port == 0) begin
      req0Valid = valid; req0Op = op; req0Data1 = a; req0Data2 = b; req0Shamt = sh;
    end else begin
      req1Valid = valid; req1Op = op; req1Data1 = a; req1Data2 = b; req1Shamt = sh;
    end
  endtask

  task automatic modelReset();
    mIdle = 1'b1; mOwner = 1'b0; mLastGrant = 1'b1; mRespCycle = 0;
    mResult = '0; mAluOp = '0; mAluData1 = '0; mAluData2 = '0; mAluShamt = '0;
  endtask

  // Observe one cycle at the falling edge, compare with the model, then advance to just after the next rising edge.
  task automatic stepCycle();
    bit grantAny, grantId, responding;
    @(negedge clk);
    grantAny   = mIdle && (req0Valid || req1Valid);
    grantId    = (req0Valid && req1Valid) ? !mLastGrant : req1Valid;
    responding = !mIdle && (cycleNum >= mRespCycle);
    if (responding && cycleNum == mRespCycle)
      mResult = aluRef(mAluOp, mAluData1, mAluData2, mAluShamt);
    checkOutput("req0_ready", 32'(req0Ready), 32'(grantAny && !grantId));
    checkOutput("req1_ready", 32'(req1Ready), 32'(grantAny && grantId));
    checkOutput("busy", 32'(busy), 32'(!mIdle));
    checkOutput("rsp0_valid", 32'(rsp0Valid), 32'(responding && !mOwner));
    checkOutput("rsp1_valid", 32'(rsp1Valid), 32'(responding && mOwner));
    checkOutput("rsp0_result", rsp0Result, mResult);
    checkOutput("rsp1_result", rsp1Result, mResult);
    checkOutput("alu_op", 32'(aluOp), 32'(mAluOp));
    checkOutput("alu_data_1", aluData1, mAluData1);
    checkOutput("alu_data_2", aluData2, mAluData2);
    checkOutput("alu_shamt", 32'(aluShamt), 32'(mAluShamt));
    acc0 = req0Valid && req0Ready;
    acc1 = req1Valid && req1Ready;
    if (acc0) grantLog.push_back(0);
    if (acc1) grantLog.push_back(1);
    if (rsp0Valid && rsp0Ready) gotRsp0 = rsp0Result;
    if (rsp1Valid && rsp1Ready) gotRsp1 = rsp1Result;
    if (rst_n && grantAny) begin
      mIdle = 1'b0; mOwner = grantId; mLastGrant = grantId;
      mRespCycle = cycleNum + LAT + 2;
      mAluOp    = grantId ? req1Op    : req0Op;
      mAluData1 = grantId ? req1Data1 : req0Data1;
      mAluData2 = grantId ? req1Data2 : req0Data2;
      mAluShamt = grantId ? req1Shamt : req0Shamt;
    end else if (rst_n && responding && (mOwner ? rsp1Ready : rsp0Ready)) begin
      mIdle = 1'b1;
    end
    @(posedge clk);
    cycleNum++;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    applyStimulus(1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    rst_n = 1'b0;
    modelReset();
    #1;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
  endtask

  task automatic randomPort(input int port, input bit accepted, inout bit valid);
    if (accepted) valid = 1'b0;
    if (!valid) begin
      if ($urandom_range(0, 99) < 40)
        applyStimulus(port, 1'b1, 4'($urandom_range(0, 7)), $urandom(),
                      ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom(),
                      5'($urandom_range(0, 31)));
    end else if ($urandom_range(0, 99) < 4) begin
      valid = 1'b0;
    end
  endtask

  initial begin
    bit v;
    rst_n = 1'b0;
    fastValid = 1'b0; fastOp = '0; fastData1 = '0; fastData2 = '0;
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;
    applyStimulus(0, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    applyStimulus(1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
    modelReset();
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_alu_op", 32'(aluOp), 32'd0);
    doReset();

    // Single request: ADD 10,5 answered three cycles after accept.
    applyStimulus(0, 1'b1, OP_ADD, 32'd10, 32'd5, 5'd0);
    stepCycle();
    checkOutput("single_accept", 32'(acc0), 32'd1);
    req0Valid = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("single_rsp0_valid", 32'(rsp0Valid), 32'd1);
    checkOutput("single_result", rsp0Result, 32'd15);
    stepCycle();
    stepCycle();

    // Simultaneous requests straight after reset: port 0 first, then port 1.
    doReset();
    grantLog.delete();
    applyStimulus(0, 1'b1, OP_SUB, 32'd15, 32'd20, 5'd0);
    applyStimulus(1, 1'b1, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      if (acc0) req0Valid = 1'b0;
      if (acc1) req1Valid = 1'b0;
    end
    checkOutput("simul_grants", 32'(grantLog.size()), 32'd2);
    checkOutput("simul_first", (grantLog.size() > 0) ? 32'(grantLog[0]) : 32'hDEAD, 32'd0);
    checkOutput("simul_rsp0", gotRsp0, 32'hFFFFFFFB);
    checkOutput("simul_rsp1", gotRsp1, 32'h00F000F0);

    // Back-pressure on port 0 while port 1 waits.
    rsp0Ready = 1'b0;
    applyStimulus(0, 1'b1, OP_OR, 32'h12340000, 32'h00005678, 5'd0);
    stepCycle();
    req0Valid = 1'b0;
    applyStimulus(1, 1'b1, OP_SLL, 32'h00000003, 32'd0, 5'd4);
    for (int i = 0; i < LAT + 1 + 5; i++) stepCycle();
    checkOutput("bp_held_result", rsp0Result, 32'h12345678);
    rsp0Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      if (acc1) req1Valid = 1'b0;
    end
    checkOutput("bp_rsp1", gotRsp1, 32'h00000030);

    // Fairness: both ports continuously valid, renewing payload on every accept.
    grantLog.delete();
    applyStimulus(0, 1'b1, OP_ADD, 32'd1, 32'd2, 5'd0);
    applyStimulus(1, 1'b1, OP_XOR, 32'd7, 32'd2, 5'd0);
    for (int i = 0; i < 13; i++) begin
      stepCycle();
      if (acc0) applyStimulus(0, 1'b1, OP_ADD, $urandom(), $urandom(), 5'd0);
      if (acc1) applyStimulus(1, 1'b1, OP_SUB, $urandom(), $urandom(), 5'd0);
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    for (int i = 0; i < 6; i++) stepCycle();
    checkOutput("fair_count", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("fair_order", (i < grantLog.size()) ? 32'(grantLog[i]) : 32'hDEAD, 32'(i % 2));

    // Reset pulsed while an operation is in BUSY: nothing may come back for it.
    applyStimulus(0, 1'b1, OP_ADD, 32'd100, 32'd1, 5'd0);
    stepCycle();
    req0Valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_alu_data_1", aluData1, 32'd0);
    checkOutput("midrst_rsp0_valid", 32'(rsp0Valid), 32'd0);
    modelReset();
    stepCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle();
    applyStimulus(0, 1'b1, OP_SRA, 32'hFFFFFFC0, 32'd0, 5'd2);
    stepCycle();
    req0Valid = 1'b0;
    for (int i = 0; i < 5; i++) stepCycle();
    checkOutput("sra_result", gotRsp0, 32'hFFFFFFF0);

    // Randomized traffic with random response back-pressure.
    for (int i = 0; i < 1500; i++) begin
      v = req0Valid; randomPort(0, acc0, v); req0Valid = v;
      v = req1Valid; randomPort(1, acc1, v); req1Valid = v;
      rsp0Ready = ($urandom_range(0, 99) < 60);
      rsp1Ready = ($urandom_range(0, 99) < 60);
      stepCycle();
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;
    for (int i = 0; i < 8; i++) stepCycle();

    // Zero-latency instance: XOR answered two cycles after accept, busy for two cycles.
    fastValid = 1'b1; fastOp = OP_XOR; fastData1 = 32'hAAAAAAAA; fastData2 = 32'h55555555;
    #1;
    checkOutput("fast_ready", 32'(fastReady), 32'd1);
    stepCycle();
    fastValid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("fast_busy", 32'(fastBusy), 32'(k <= 2));
      checkOutput("fast_rsp_valid", 32'(fastRspValid), 32'(k == 2));
      checkOutput("fast_rsp1_valid", 32'(fastRsp1Valid), 32'd0);
      checkOutput("fast_req1_ready", 32'(fastReq1Ready), 32'd0);
      if (k == 2) begin
        checkOutput("fast_result", fastRspResult, 32'hFFFFFFFF);
        checkOutput("fast_result1", fastRsp1Result, 32'hFFFFFFFF);
      end
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
